// File: rtl/fifo_stream_if.sv
// fifo_stream_if: producer and consumer valid/ready streams around fifo_stream.
interface fifo_stream_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/fifo_stream.sv
// fifo_stream: FWFT valid/ready FIFO, sync-read array plus 2-entry prefetch skid.
// Define FIFO_FLUSH_EN to add the flush port.
module fifo_stream #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 256,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  localparam int LW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef FIFO_FLUSH_EN
  input  logic          flush,
`endif
  fifo_stream_if.slave  s,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    mem_cnt, level_nxt;
  logic [WIDTH-1:0] rd_data, q0, q1;
  logic [1:0]       q_cnt, slot;
  logic             pending, ready_q, clr, accept, pop, rd_en;
`ifdef FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign accept    = s.in_valid && ready_q;
  assign pop       = s.out_ready && (q_cnt != 2'd0);
  // Issue a read only if the word still has a skid slot when it lands two edges later.
  assign rd_en     = (mem_cnt != '0) && ({1'b0, q_cnt} + {2'b0, pending} - {2'b0, pop} <= 3'd1);
  assign slot      = q_cnt - {1'b0, pop};
  assign level_nxt = level + LW'(accept) - LW'(pop);
  assign s.in_ready    = ready_q;
  assign s.out_valid   = q_cnt != 2'd0;
  assign s.out_data    = q0;
  assign almost_full   = int'(level) >= AFULL_THRESH;
  assign almost_empty  = int'(level) <= AEMPTY_THRESH;
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= s.in_data;
    if (rd_en) rd_data <= mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      level   <= '0;
      q_cnt   <= 2'd0;
      pending <= 1'b0;
      ready_q <= rst_n;
      q0      <= '0;
      q1      <= '0;
    end else begin
      if (accept) wr_ptr <= inc(wr_ptr);
      if (rd_en) rd_ptr <= inc(rd_ptr);
      mem_cnt <= mem_cnt + LW'(accept) - LW'(rd_en);
      level   <= level_nxt;
      ready_q <= level_nxt < LW'(DEPTH);
      pending <= rd_en;
      q_cnt   <= q_cnt - {1'b0, pop} + {1'b0, pending};
      if (pop) q0 <= q1;
      if (pending && slot == 2'd0) q0 <= rd_data;
      if (pending && slot == 2'd1) q1 <= rd_data;
    end
  end
endmodule

// File: tb/tb_fifo_stream.sv
// tb_fifo_stream: directed vectors, streaming and random checks for fifo_stream (DEPTH=5).
module tb_fifo_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] level;
  logic       almost_full, almost_empty;
`ifdef FIFO_FLUSH_EN
  logic       flush = 1'b0;
`endif
  fifo_stream_if #(.WIDTH(8)) bus ();
  fifo_stream #(.WIDTH(8), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FIFO_FLUSH_EN
    .flush(flush),
`endif
    .s(bus),
    .level(level),
    .almost_full(almost_full),
    .almost_empty(almost_empty)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic [2:0] lvl;
    logic       ir;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t       vt [16];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] q [$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
    logic       ir, ov;
    logic [7:0] od, e;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    ir = bus.in_ready;
    ov = bus.out_valid;
    od = bus.out_data;
    @(posedge clk); #1;
    if (iv && ir) q.push_back(d);
    if (ov && ordy) begin
      if (q.size() == 0) chk("pop_underflow", 32'(od), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("pop_data", 32'(od), 32'(e));
      end
    end
    chk("level_model", 32'(level), 32'(q.size()));
    if (ov && !ordy) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(od));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(level), 32'd0);
  endtask

  initial begin
    int sent, gaps;
    vt[0]  = {1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1};
    vt[1]  = {1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0};
    vt[2]  = {1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[3]  = {1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1, 1'b1, 1'b0};
    vt[4]  = {1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 3'd5, 1'b0, 1'b1, 1'b0};
    vt[5]  = {1'b1, 8'h06, 1'b0, 1'b1, 8'h01, 3'd5, 1'b0, 1'b1, 1'b0};
    vt[6]  = {1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 3'd4, 1'b1, 1'b1, 1'b0};
    vt[7]  = {1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[8]  = {1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
    vt[9]  = {1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 3'd1, 1'b1, 1'b0, 1'b1};
    vt[10] = {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1};
    vt[11] = {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1};
    vt[12] = {1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1};
    vt[13] = {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1};
    vt[14] = {1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b0, 1'b1};
    vt[15] = {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1};
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_out_data", 32'(bus.out_data), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_aempty", 32'(almost_empty), 32'd1);
    chk("idle_afull", 32'(almost_full), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = vt[i].iv;
      bus.in_data = vt[i].d;
      bus.out_ready = vt[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
      if (vt[i].ov) chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vt[i].od));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].ir));
      chk($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vt[i].af));
      chk($sformatf("vec%0d_aempty", i), 32'(almost_empty), 32'(vt[i].ae));
    end
    q.delete();
    // Full-rate streaming across many pointer wraps.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    sent = 2;
    gaps = 0;
    for (int c = 0; c < 1200 && sent < 1000; c++) begin
      if (c >= 3 && !(bus.out_valid && bus.in_ready)) gaps++;
      if (bus.in_ready) sent++;
      cyc(1'b1, 8'(sent - (bus.in_ready ? 1 : 0)), 1'b1);
    end
    chk("stream_sent", 32'(sent), 32'd1000);
    chk("stream_gaps", 32'(gaps), 32'd0);
    drain();
    for (int c = 0; c < 10000; c++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain();
    // Reset in the middle of a burst discards everything.
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data", 32'(bus.out_data), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("mrst_release_ready", 32'(bus.in_ready), 32'd1);
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mrst_repush_data", 32'(bus.out_data), 32'h5A);
    drain();
`ifdef FIFO_FLUSH_EN
    cyc(1'b1, 8'h44, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("flush_pre_level", 32'(level), 32'd3);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("flush_after_valid", 32'(bus.out_valid), 32'd1);
    chk("flush_after_data", 32'(bus.out_data), 32'h3C);
    drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
